// File: rtl/present16_dec_ctrl.sv
// Iterative PRESENT-16 decryption round controller: whiten with K[ROUNDS+1], then ROUNDS inverse rounds.
// Optional abort input is enabled by defining PRESENT16_DEC_ABORT_EN.
module present16_dec_ctrl #(
    parameter int ROUNDS = 15,
    parameter int RKI_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [RKI_W-1:0] rk_idx,
    input  logic [15:0]      rk_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             busy
`ifdef PRESENT16_DEC_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WHITEN = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [RKI_W-1:0] LP_RK_LAST = RKI_W'(ROUNDS + 1);
    localparam logic [RKI_W-1:0] LP_CNT_INIT = RKI_W'(ROUNDS);

    state_t            r_fsm;
    state_t            w_fsm_nxt;
    logic [15:0]       r_state;
    logic [RKI_W-1:0]  r_cnt;
    logic [15:0]       w_round;
    logic              w_abort;

`ifdef PRESENT16_DEC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Inverse pLayer: out[i] = in[4*i mod 15], bit 15 is fixed.
    function automatic logic [15:0] pinv(input logic [15:0] x);
        logic [15:0] y;
        y[15] = x[15];
        for (int i = 0; i < 15; i++) begin
            y[4'(i)] = x[4'((4 * i) % 15)];
        end
        return y;
    endfunction

    function automatic logic [3:0] sinv4(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h5;
            4'h1: r = 4'hE;
            4'h2: r = 4'hF;
            4'h3: r = 4'h8;
            4'h4: r = 4'hC;
            4'h5: r = 4'h1;
            4'h6: r = 4'h2;
            4'h7: r = 4'hD;
            4'h8: r = 4'hB;
            4'h9: r = 4'h4;
            4'hA: r = 4'h6;
            4'hB: r = 4'h3;
            4'hC: r = 4'h0;
            4'hD: r = 4'h7;
            4'hE: r = 4'h9;
            default: r = 4'hA;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sbox_layer_inv(input logic [15:0] x);
        return {sinv4(x[15:12]), sinv4(x[11:8]), sinv4(x[7:4]), sinv4(x[3:0])};
    endfunction

    assign w_round = sbox_layer_inv(pinv(r_state)) ^ rk_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:   if (in_valid) w_fsm_nxt = S_WHITEN;
            S_WHITEN: w_fsm_nxt = w_abort ? S_IDLE : S_ROUND;
            S_ROUND: begin
                if (w_abort)           w_fsm_nxt = S_IDLE;
                else if (r_cnt == 'd1) w_fsm_nxt = S_DONE;
            end
            default:  if (w_abort || out_ready) w_fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = '0;
        case (r_fsm)
            S_IDLE:   in_ready = 1'b1;
            S_WHITEN: begin
                busy   = 1'b1;
                rk_idx = LP_RK_LAST;
            end
            S_ROUND: begin
                busy   = 1'b1;
                rk_idx = r_cnt;
            end
            default:  out_valid = 1'b1;
        endcase
    end

    // Round datapath; abort clears the block so nothing stale can leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) r_state <= in_data;
                end
                S_WHITEN: begin
                    if (w_abort) begin
                        r_state <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= r_state ^ rk_in;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                S_ROUND: begin
                    if (w_abort) begin
                        r_state <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= w_round;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (w_abort) begin
                        r_state <= '0;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign out_data = r_state;

endmodule

// File: tb/tb_present16_dec_ctrl.sv
// Directed bench for present16_dec_ctrl: one ROUNDS=1 instance (hand vectors) and one ROUNDS=15 instance.
module tb_present16_dec_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ROUNDS=1 instance
    logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0, busy1;
    logic [15:0] in_data1 = 0, rk_in1, out_data1;
    logic [1:0]  rk_idx1;
    logic [15:0] key1 [4];
    assign rk_in1 = key1[rk_idx1];

    // ROUNDS=15 instance
    logic        in_valid15 = 0, in_ready15, out_valid15, out_ready15 = 0, busy15;
    logic [15:0] in_data15 = 0, rk_in15, out_data15;
    logic [4:0]  rk_idx15;
    logic [15:0] key15 [32];
    assign rk_in15 = key15[rk_idx15];

    logic abort1 = 0, abort15 = 0;

    present16_dec_ctrl #(.ROUNDS(1), .RKI_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .rk_idx(rk_idx1), .rk_in(rk_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .busy(busy1)
`ifdef PRESENT16_DEC_ABORT_EN
        , .abort(abort1)
`endif
    );

    present16_dec_ctrl u15 (
        .clk(clk), .rst(rst), .in_valid(in_valid15), .in_ready(in_ready15), .in_data(in_data15),
        .rk_idx(rk_idx15), .rk_in(rk_in15), .out_valid(out_valid15), .out_ready(out_ready15),
        .out_data(out_data15), .busy(busy15)
`ifdef PRESENT16_DEC_ABORT_EN
        , .abort(abort15)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decryption for the ROUNDS=15 instance, written source-bit-forward.
    function automatic logic [15:0] model15(input logic [15:0] ct);
        logic [15:0] s, p, q;
        logic [63:0] sb;
        sb = 64'hA970_364B_D21C_8FE5;
        s = ct ^ key15[16];
        for (int r = 15; r >= 1; r--) begin
            p[15] = s[15];
            for (int j = 0; j < 15; j++) p[(4 * j) % 15] = s[j];
            for (int n = 0; n < 4; n++) q[4*n +: 4] = sb[4*p[4*n +: 4] +: 4];
            s = q ^ key15[r];
        end
        return s;
    endfunction

    task automatic run1(input logic [15:0] ct, input logic [15:0] k2, input logic [15:0] k1,
                        input logic [15:0] exp);
        key1[2]    = k2;
        key1[1]    = k1;
        in_data1   = ct;
        in_valid1  = 1;
        out_ready1 = 1;
        chk("u1 idle in_ready", in_ready1, 1);
        step();
        chk("u1 whiten busy", busy1, 1);
        chk("u1 whiten rk_idx", rk_idx1, 2);
        chk("u1 whiten out_valid", out_valid1, 0);
        in_data1 = 16'hDEAD;
        step();
        in_valid1 = 0;
        chk("u1 round rk_idx", rk_idx1, 1);
        chk("u1 round busy", busy1, 1);
        step();
        chk("u1 done out_valid", out_valid1, 1);
        chk("u1 done out_data", out_data1, exp);
        chk("u1 done busy", busy1, 0);
        step();
        chk("u1 back idle in_ready", in_ready1, 1);
        chk("u1 back idle out_valid", out_valid1, 0);
        out_ready1 = 0;
    endtask

    // Entered right after the accepting edge; leaves the DUT in IDLE with out_ready15=1.
    task automatic blk15(input logic [15:0] ct, input logic [15:0] nxt, input int hold);
        logic [15:0] e;
        e = model15(ct);
        in_data15 = nxt;
        chk("u15 whiten rk_idx", rk_idx15, 16);
        chk("u15 whiten busy", busy15, 1);
        for (int k = 15; k >= 1; k--) begin
            step();
            chk("u15 round rk_idx", rk_idx15, k);
        end
        step();
        chk("u15 done out_valid", out_valid15, 1);
        chk("u15 done out_data", out_data15, e);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("u15 hold out_valid", out_valid15, 1);
            chk("u15 hold out_data", out_data15, e);
            chk("u15 hold in_ready", in_ready15, 0);
        end
        out_ready15 = 1;
        step();
        chk("u15 bubble in_ready", in_ready15, 1);
        chk("u15 bubble out_valid", out_valid15, 0);
        chk("u15 bubble busy", busy15, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        for (int i = 0; i < 4; i++) key1[i] = 16'h0000;
        for (int i = 0; i < 32; i++) key15[i] = 16'(i * 40503 + 4660) ^ 16'(i << 9);

        rst = 1;
        step();
        step();
        chk("rst u1 in_ready", in_ready1, 1);
        chk("rst u15 in_ready", in_ready15, 1);
        chk("rst u15 out_valid", out_valid15, 0);
        chk("rst u15 out_data", out_data15, 0);
        chk("rst u15 rk_idx", rk_idx15, 0);
        chk("rst u15 busy", busy15, 0);
        rst = 0;
        step();

        // ROUNDS=1 hand-computed vectors
        run1(16'h0000, 16'h0000, 16'h0000, 16'h5555);
        run1(16'hFFFF, 16'h0000, 16'h0000, 16'hAAAA);
        run1(16'h0000, 16'hFFFF, 16'h1234, 16'hB89E);
        run1(16'h0000, 16'h0002, 16'h0000, 16'h55E5);
        run1(16'h0000, 16'h0008, 16'h0000, 16'hE555);

        // ROUNDS=15: held DONE, then back-to-back blocks
        in_valid15  = 1;
        in_data15   = 16'h4A7C;
        out_ready15 = 0;
        step();
        blk15(16'h4A7C, 16'h1357, 10);
        step();
        chk("u15 accept after bubble", busy15, 1);
        acc = cyc;
        blk15(16'h1357, 16'hF00D, 0);
        step();
        chk("u15 b2b accept", busy15, 1);
        chk("u15 b2b spacing", cyc - acc, 18);
        blk15(16'hF00D, 16'h0000, 0);
        in_valid15 = 0;
        step();
        chk("u15 no accept without valid", in_ready15, 1);
        out_ready15 = 0;

        // Reset in the middle of a ROUND
        in_valid15 = 1;
        in_data15  = 16'h0BAD;
        step();
        in_valid15 = 0;
        step();
        for (int i = 0; i < 8; i++) step();
        chk("u15 mid-round rk_idx", rk_idx15, 7);
        rst = 1;
        step();
        rst = 0;
        chk("mid rst in_ready", in_ready15, 1);
        chk("mid rst out_valid", out_valid15, 0);
        chk("mid rst out_data", out_data15, 0);
        chk("mid rst busy", busy15, 0);
        chk("mid rst rk_idx", rk_idx15, 0);
        in_valid15 = 1;
        in_data15  = 16'h2468;
        step();
        in_valid15 = 0;
        blk15(16'h2468, 16'h0000, 0);
        out_ready15 = 0;

`ifdef PRESENT16_DEC_ABORT_EN
        in_valid15 = 1;
        in_data15  = 16'h7777;
        abort15    = 1;
        step();
        chk("abort idle no effect", busy15, 1);
        abort15    = 0;
        in_valid15 = 0;
        step();
        step();
        abort15 = 1;
        step();
        abort15 = 0;
        chk("abort round in_ready", in_ready15, 1);
        chk("abort round busy", busy15, 0);
        chk("abort round out_data", out_data15, 0);
        in_valid15 = 1;
        in_data15  = 16'h8888;
        step();
        in_valid15 = 0;
        for (int i = 0; i < 16; i++) step();
        chk("abort done out_valid", out_valid15, 1);
        abort15     = 1;
        out_ready15 = 1;
        step();
        abort15     = 0;
        out_ready15 = 0;
        chk("abort done out_valid drop", out_valid15, 0);
        chk("abort done out_data", out_data15, 0);
        chk("abort done in_ready", in_ready15, 1);
        in_valid15 = 1;
        in_data15  = 16'hC0DE;
        step();
        in_valid15 = 0;
        blk15(16'hC0DE, 16'h0000, 0);
        out_ready15 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
